// File: rtl/mac_learning_pkg.sv
// Shared types and constants for the MAC learning controller.
package mac_learning_pkg;

   localparam int          GROUP_BIT     = 40;
   localparam logic [47:0] BROADCAST_KEY = 48'hFFFF_FFFF_FFFF;

   typedef enum logic [3:0] {
      IDLE,
      DST_MATCH,
      DST_RESULT,
      SRC_RESULT,
      SRC_DELETE,
      SRC_WRITE,
      DECIDE,
      REMOVE_MATCH,
      REMOVE_RESULT
   } mac_learning_state_t;

endpackage

// File: rtl/mac_learning_controller_if.sv
// Descriptor, decision, removal, CAM-command and occupancy signals of the MAC learning controller.
// master is the controller's view; slave is the view of the surrounding switch logic and CAM.
interface mac_learning_controller_if #(
   parameter int KEY_WIDTH   = 48,
   parameter int TABLE_DEPTH = 32,
   parameter int INDEX_DEPTH = 8
);
   localparam int IW = $clog2(INDEX_DEPTH);
   localparam int CW = $clog2(TABLE_DEPTH + 1);

   logic                 lookup_valid;
   logic                 lookup_ready;
   logic [KEY_WIDTH-1:0] lookup_destination_key;
   logic [KEY_WIDTH-1:0] lookup_source_key;
   logic [IW-1:0]        lookup_ingress_index;

   logic                 decision_valid;
   logic                 decision_ready;
   logic [IW-1:0]        decision_index;
   logic                 decision_flood;
   logic                 decision_drop;

   logic                 remove_valid;
   logic                 remove_ready;
   logic [KEY_WIDTH-1:0] remove_key;

   logic                 cam_write_enable;
   logic                 cam_match_enable;
   logic                 cam_delete_enable;
   logic [KEY_WIDTH-1:0] cam_key;
   logic [IW-1:0]        cam_index;
   logic [IW-1:0]        cam_match_index;
   logic                 cam_match_valid;
   logic                 cam_no_match;

   logic [CW-1:0]        table_count;
   logic                 table_full;
   logic                 learn_overflow;

   modport master (
      input  lookup_valid, lookup_destination_key, lookup_source_key, lookup_ingress_index,
      output lookup_ready,
      output decision_valid, decision_index, decision_flood, decision_drop,
      input  decision_ready,
      input  remove_valid, remove_key,
      output remove_ready,
      output cam_write_enable, cam_match_enable, cam_delete_enable, cam_key, cam_index,
      input  cam_match_index, cam_match_valid, cam_no_match,
      output table_count, table_full, learn_overflow
   );

   modport slave (
      output lookup_valid, lookup_destination_key, lookup_source_key, lookup_ingress_index,
      input  lookup_ready,
      input  decision_valid, decision_index, decision_flood, decision_drop,
      output decision_ready,
      output remove_valid, remove_key,
      input  remove_ready,
      input  cam_write_enable, cam_match_enable, cam_delete_enable, cam_key, cam_index,
      output cam_match_index, cam_match_valid, cam_no_match,
      input  table_count, table_full, learn_overflow
   );

endinterface

// File: rtl/mac_learning_controller.sv
// Sequences CAM match/learn/delete commands per frame descriptor and returns a forwarding decision.
// Also services address removals and tracks table occupancy so the CAM is never written while full.
module mac_learning_controller
   import mac_learning_pkg::*;
#(
   parameter int KEY_WIDTH   = 48,
   parameter int TABLE_DEPTH = 32,
   parameter int INDEX_DEPTH = 8
) (
   input logic                       clock,
   input logic                       reset_n,
   mac_learning_controller_if.master bus
);
   localparam int            IW         = $clog2(INDEX_DEPTH);
   localparam int            CW         = $clog2(TABLE_DEPTH + 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(TABLE_DEPTH);
   localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

   mac_learning_state_t state, state_next;

   logic                 last_was_lookup;
   logic [KEY_WIDTH-1:0] destination_key;
   logic [KEY_WIDTH-1:0] source_key;
   logic [KEY_WIDTH-1:0] removal_key;
   logic [IW-1:0]        ingress_index;
   logic [IW-1:0]        destination_index;
   logic                 destination_hit;
   logic                 move_pending;
   logic                 learn_blocked;
   logic                 lookup_accept;
   logic                 remove_accept;
   logic                 count_up;
   logic                 count_down;
   logic                 flood_next;
   logic                 drop_next;

   assign flood_next = destination_key[GROUP_BIT] || !destination_hit;
   assign drop_next  = !flood_next && (destination_index == ingress_index);
   assign count_up   = (state == SRC_WRITE) && !move_pending && !learn_blocked && !bus.table_full;
   assign count_down = (state == REMOVE_RESULT) && bus.cam_match_valid && (bus.table_count != '0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next            = state;
      bus.lookup_ready      = 1'b0;
      bus.remove_ready      = 1'b0;
      bus.cam_write_enable  = 1'b0;
      bus.cam_match_enable  = 1'b0;
      bus.cam_delete_enable = 1'b0;
      bus.cam_key           = '0;
      bus.cam_index         = '0;
      lookup_accept         = 1'b0;
      remove_accept         = 1'b0;
      unique case (state)
         IDLE: begin
            // Whichever requester was served last yields under contention.
            bus.lookup_ready = !(bus.remove_valid && last_was_lookup);
            bus.remove_ready = !(bus.lookup_valid && !last_was_lookup);
            lookup_accept    = bus.lookup_valid && !(bus.remove_valid && last_was_lookup);
            remove_accept    = bus.remove_valid && !(bus.lookup_valid && !last_was_lookup);
            if (lookup_accept)      state_next = DST_MATCH;
            else if (remove_accept) state_next = REMOVE_MATCH;
         end
         DST_MATCH: begin
            bus.cam_match_enable = 1'b1;
            bus.cam_key          = destination_key;
            state_next           = DST_RESULT;
         end
         DST_RESULT: begin
            bus.cam_match_enable = 1'b1;
            bus.cam_key          = source_key;
            state_next           = SRC_RESULT;
         end
         SRC_RESULT: begin
            if (bus.cam_match_valid)
               state_next = (bus.cam_match_index == ingress_index) ? DECIDE : SRC_DELETE;
            else
               state_next = SRC_WRITE;
         end
         SRC_DELETE: begin
            bus.cam_delete_enable = 1'b1;
            bus.cam_key           = source_key;
            state_next            = SRC_WRITE;
         end
         SRC_WRITE: begin
            // A full-table miss still spends this slot with the write suppressed.
            bus.cam_write_enable = !learn_blocked;
            bus.cam_key          = source_key;
            bus.cam_index        = ingress_index;
            state_next           = DECIDE;
         end
         DECIDE: begin
            if (bus.decision_ready) state_next = IDLE;
         end
         REMOVE_MATCH: begin
            bus.cam_match_enable = 1'b1;
            bus.cam_key          = removal_key;
            state_next           = REMOVE_RESULT;
         end
         REMOVE_RESULT: begin
            bus.cam_delete_enable = bus.cam_match_valid;
            bus.cam_key           = removal_key;
            state_next            = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_was_lookup    <= 1'b0;
         destination_key    <= '0;
         source_key         <= '0;
         removal_key        <= '0;
         ingress_index      <= '0;
         destination_index  <= '0;
         destination_hit    <= 1'b0;
         move_pending       <= 1'b0;
         learn_blocked      <= 1'b0;
         bus.decision_valid <= 1'b0;
         bus.decision_flood <= 1'b0;
         bus.decision_drop  <= 1'b0;
         bus.decision_index <= '0;
         bus.table_count    <= '0;
         bus.table_full     <= 1'b0;
         bus.learn_overflow <= 1'b0;
      end else begin
         bus.learn_overflow <= 1'b0;
         if (lookup_accept) begin
            destination_key <= bus.lookup_destination_key;
            source_key      <= bus.lookup_source_key;
            ingress_index   <= bus.lookup_ingress_index;
            last_was_lookup <= 1'b1;
         end
         if (remove_accept) begin
            removal_key     <= bus.remove_key;
            last_was_lookup <= 1'b0;
         end
         // Destination result reflects the table before this frame's learning.
         if (state == DST_RESULT) begin
            destination_hit   <= bus.cam_match_valid;
            destination_index <= bus.cam_match_index;
         end
         if (state == SRC_RESULT) begin
            move_pending       <= bus.cam_match_valid;
            learn_blocked      <= !bus.cam_match_valid && bus.table_full;
            bus.learn_overflow <= !bus.cam_match_valid && bus.table_full;
         end
         if (state != DECIDE && state_next == DECIDE) begin
            bus.decision_valid <= 1'b1;
            bus.decision_flood <= flood_next;
            bus.decision_drop  <= drop_next;
            bus.decision_index <= (flood_next || drop_next) ? '0 : destination_index;
         end else if (state == DECIDE && bus.decision_ready) begin
            bus.decision_valid <= 1'b0;
         end
         if (count_up) begin
            bus.table_count <= bus.table_count + COUNT_ONE;
            bus.table_full  <= (bus.table_count + COUNT_ONE) == FULL_COUNT;
         end else if (count_down) begin
            bus.table_count <= bus.table_count - COUNT_ONE;
            bus.table_full  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mac_learning_controller.sv
// Bench for mac_learning_controller: behavioural CAM, directed vector table, multi-cycle corner
// sequences, and randomized traffic checked against an associative-array model of the table.
module tb_mac_learning_controller;
   import mac_learning_pkg::*;

   localparam int KW = 48;
   localparam int TD = 32;
   localparam int ID = 8;

   localparam logic [47:0] KA = 48'h02_00_00_00_00_0A;
   localparam logic [47:0] KB = 48'h02_00_00_00_00_0B;
   localparam logic [47:0] KC = 48'h02_00_00_00_00_0C;
   localparam logic [47:0] KD = 48'h02_00_00_00_00_0D;
   localparam logic [47:0] KE = 48'h02_00_00_00_00_EE;
   localparam logic [47:0] KM = 48'h01_00_5E_00_00_01;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   mac_learning_controller_if #(.KEY_WIDTH(KW), .TABLE_DEPTH(TD), .INDEX_DEPTH(ID)) bus ();

   mac_learning_controller #(.KEY_WIDTH(KW), .TABLE_DEPTH(TD), .INDEX_DEPTH(ID)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Behavioural CAM: commands act at the edge, match results registered for the next cycle.
   logic [47:0] cam_keys [TD];
   logic [2:0]  cam_ports[TD];
   logic        cam_used [TD];

   always @(posedge clock or negedge reset_n) begin
      int hit, free;
      if (!reset_n) begin
         for (int i = 0; i < TD; i++) cam_used[i] = 1'b0;
         bus.cam_match_valid <= 1'b0;
         bus.cam_no_match    <= 1'b0;
         bus.cam_match_index <= '0;
      end else begin
         hit  = -1;
         free = -1;
         for (int i = 0; i < TD; i++) begin
            if (cam_used[i] && cam_keys[i] == bus.cam_key) hit = i;
            if (!cam_used[i] && free < 0) free = i;
         end
         if (bus.cam_write_enable || bus.cam_match_enable || bus.cam_delete_enable)
            check("cam_one_command", 64'(bus.cam_write_enable) + 64'(bus.cam_match_enable)
                  + 64'(bus.cam_delete_enable), 1);
         bus.cam_match_valid <= bus.cam_match_enable && hit >= 0;
         bus.cam_no_match    <= bus.cam_match_enable && hit < 0;
         bus.cam_match_index <= (hit >= 0) ? cam_ports[hit] : 3'd0;
         if (bus.cam_write_enable) begin
            check("cam_write_duplicate", hit >= 0, 0);
            check("cam_write_no_space", free < 0, 0);
            if (hit < 0 && free >= 0) begin
               cam_used[free]  = 1'b1;
               cam_keys[free]  = bus.cam_key;
               cam_ports[free] = bus.cam_index;
            end
         end
         if (bus.cam_delete_enable && hit >= 0) cam_used[hit] = 1'b0;
      end
   end

   logic       r_flood, r_drop;
   logic [2:0] r_idx;
   int         r_lat, r_wr, r_del, r_ovf;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_lookup(input logic [47:0] da, input logic [47:0] sa, input logic [2:0] ing,
                            input int hold);
      int guard;
      bus.lookup_destination_key = da;
      bus.lookup_source_key      = sa;
      bus.lookup_ingress_index   = ing;
      bus.lookup_valid           = 1'b1;
      #1;
      guard = 0;
      while (!bus.lookup_ready && guard < 50) begin
         tick();
         guard++;
      end
      check("lookup_accept_timeout", guard >= 50, 0);
      tick();
      bus.lookup_valid = 1'b0;
      r_lat = 1;
      r_wr  = 0;
      r_del = 0;
      r_ovf = 0;
      while (1) begin
         r_wr  += int'(bus.cam_write_enable);
         r_del += int'(bus.cam_delete_enable);
         r_ovf += int'(bus.learn_overflow);
         if (bus.decision_valid || r_lat >= 20) break;
         tick();
         r_lat++;
      end
      r_flood = bus.decision_flood;
      r_drop  = bus.decision_drop;
      r_idx   = bus.decision_index;
      for (int h = 0; h < hold; h++) begin
         tick();
         check("hold_stable", {bus.decision_valid, bus.decision_flood, bus.decision_drop,
                               bus.decision_index, bus.lookup_ready},
               {1'b1, r_flood, r_drop, r_idx, 1'b0});
      end
      bus.decision_ready = 1'b1;
      tick();
      bus.decision_ready = 1'b0;
      check("decision_release", bus.decision_valid, 1'b0);
   endtask

   task automatic do_remove(input logic [47:0] key);
      int guard;
      bus.remove_key   = key;
      bus.remove_valid = 1'b1;
      #1;
      guard = 0;
      while (!bus.remove_ready && guard < 50) begin
         tick();
         guard++;
      end
      check("remove_accept_timeout", guard >= 50, 0);
      tick();
      bus.remove_valid = 1'b0;
      r_del = 0;
      for (int c = 0; c < 2; c++) begin
         r_del += int'(bus.cam_delete_enable);
         tick();
      end
      check("remove_occupancy", {bus.lookup_ready, bus.remove_ready}, 2'b11);
   endtask

   function automatic logic [47:0] pkey(input int i);
      logic [47:0] k;
      k = 48'h02_00_00_00_10_00 + 48'(i);
      if (i % 7 == 3) k[GROUP_BIT] = 1'b1;
      return k;
   endfunction

   function automatic logic [47:0] fkey(input int i);
      return 48'h02_00_00_00_20_00 + 48'(i);
   endfunction

   typedef struct {
      logic [47:0] da;
      logic [47:0] sa;
      logic [2:0]  ing;
      logic        flood;
      logic        drop;
      logic [2:0]  idx;
      int          lat;
      int          wr;
      int          del;
      int          count;
   } vec_t;

   vec_t vecs[9];
   logic [2:0] ref_tab [logic [47:0]];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1);
   end

   initial begin
      int prev, n_acc, cyc, guard;
      logic acc_l, acc_r;

      vecs[0] = '{KB, KA, 3'd3, 1'b1, 1'b0, 3'd0, 5, 1, 0, 1};
      vecs[1] = '{KA, KB, 3'd5, 1'b0, 1'b0, 3'd3, 5, 1, 0, 2};
      vecs[2] = '{KA, KA, 3'd3, 1'b0, 1'b1, 3'd0, 4, 0, 0, 2};
      vecs[3] = '{KB, KA, 3'd6, 1'b0, 1'b0, 3'd5, 6, 1, 1, 2};
      vecs[4] = '{KA, KB, 3'd5, 1'b0, 1'b0, 3'd6, 4, 0, 0, 2};
      vecs[5] = '{BROADCAST_KEY, KB, 3'd5, 1'b1, 1'b0, 3'd0, 4, 0, 0, 2};
      vecs[6] = '{KB, KM, 3'd2, 1'b0, 1'b0, 3'd5, 5, 1, 0, 3};
      vecs[7] = '{KM, KB, 3'd5, 1'b1, 1'b0, 3'd0, 4, 0, 0, 3};
      vecs[8] = '{KC, KC, 3'd1, 1'b1, 1'b0, 3'd0, 5, 1, 0, 4};

      bus.lookup_valid           = 1'b0;
      bus.lookup_destination_key = '0;
      bus.lookup_source_key      = '0;
      bus.lookup_ingress_index   = '0;
      bus.decision_ready         = 1'b0;
      bus.remove_valid           = 1'b0;
      bus.remove_key             = '0;

      repeat (3) @(posedge clock);
      #1;
      check("reset_lookup_ready", bus.lookup_ready, 1'b1);
      check("reset_remove_ready", bus.remove_ready, 1'b1);
      check("reset_cam_cmds", {bus.cam_write_enable, bus.cam_match_enable, bus.cam_delete_enable}, 0);
      check("reset_cam_key_index", {bus.cam_key, bus.cam_index}, 0);
      check("reset_decision", {bus.decision_valid, bus.decision_flood, bus.decision_drop,
                               bus.decision_index}, 0);
      check("reset_count", bus.table_count, 0);
      check("reset_full_ovf", {bus.table_full, bus.learn_overflow}, 0);
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 9; i++) begin
         do_lookup(vecs[i].da, vecs[i].sa, vecs[i].ing, 0);
         check($sformatf("vec%0d_flood", i), r_flood, vecs[i].flood);
         check($sformatf("vec%0d_drop", i), r_drop, vecs[i].drop);
         check($sformatf("vec%0d_index", i), (r_flood || r_drop) ? 3'd0 : r_idx,
               (vecs[i].flood || vecs[i].drop) ? 3'd0 : vecs[i].idx);
         check($sformatf("vec%0d_latency", i), r_lat, vecs[i].lat);
         check($sformatf("vec%0d_writes", i), r_wr, vecs[i].wr);
         check($sformatf("vec%0d_deletes", i), r_del, vecs[i].del);
         check($sformatf("vec%0d_count", i), bus.table_count, vecs[i].count);
      end

      // Decision backpressure for 10 cycles.
      do_lookup(KA, KB, 3'd5, 10);
      check("bp_index", r_idx, 3'd6);
      check("bp_latency", r_lat, 4);

      // Contention: both requesters held high; service must alternate.
      bus.lookup_destination_key = KB;
      bus.lookup_source_key      = KB;
      bus.lookup_ingress_index   = 3'd5;
      bus.lookup_valid           = 1'b1;
      bus.remove_key             = KE;
      bus.remove_valid           = 1'b1;
      bus.decision_ready         = 1'b1;
      #1;
      prev  = -1;
      n_acc = 0;
      cyc   = 0;
      while (n_acc < 6 && cyc < 200) begin
         acc_l = bus.lookup_valid && bus.lookup_ready;
         acc_r = bus.remove_valid && bus.remove_ready;
         if (acc_l || acc_r) begin
            check("arb_exclusive", acc_l && acc_r, 1'b0);
            if (prev >= 0) check("arb_alternate", acc_l, prev == 0);
            prev = acc_l ? 1 : 0;
            n_acc++;
         end
         tick();
         cyc++;
      end
      check("arb_accepts", n_acc, 6);
      bus.lookup_valid = 1'b0;
      bus.remove_valid = 1'b0;
      guard = 0;
      while (!(bus.lookup_ready && bus.remove_ready) && guard < 20) begin
         tick();
         guard++;
      end
      bus.decision_ready = 1'b0;
      check("arb_idle", {bus.lookup_ready, bus.remove_ready}, 2'b11);
      check("arb_count", bus.table_count, 4);

      // Reset in the middle of a learning lookup.
      bus.lookup_destination_key = KB;
      bus.lookup_source_key      = KD;
      bus.lookup_ingress_index   = 3'd0;
      bus.lookup_valid           = 1'b1;
      repeat (3) tick();
      bus.lookup_valid = 1'b0;
      reset_n = 1'b0;
      #2;
      check("midreset_decision", bus.decision_valid, 1'b0);
      check("midreset_count", {bus.table_full, bus.table_count}, 0);
      check("midreset_cam_idle", {bus.cam_write_enable, bus.cam_match_enable, bus.cam_delete_enable}, 0);
      check("midreset_ready", bus.lookup_ready, 1'b1);
      tick();
      reset_n = 1'b1;
      tick();

      // Fill the table, then overflow, removal and relearn.
      for (int i = 0; i < TD; i++) begin
         do_lookup(BROADCAST_KEY, fkey(i), 3'(i), 0);
         check($sformatf("fill%0d_latency", i), r_lat, 5);
      end
      check("fill_count", bus.table_count, TD);
      check("fill_full", bus.table_full, 1'b1);
      do_lookup(fkey(3), fkey(100), 3'd2, 0);
      check("ovf_pulses", r_ovf, 1);
      check("ovf_writes", r_wr, 0);
      check("ovf_latency", r_lat, 5);
      check("ovf_index", r_idx, 3'd3);
      check("ovf_count", bus.table_count, TD);
      do_remove(fkey(7));
      check("rm_hit_deletes", r_del, 1);
      check("rm_hit_count", bus.table_count, TD - 1);
      check("rm_hit_full", bus.table_full, 1'b0);
      do_remove(fkey(200));
      check("rm_miss_deletes", r_del, 0);
      check("rm_miss_count", bus.table_count, TD - 1);
      do_lookup(BROADCAST_KEY, fkey(100), 3'd2, 0);
      check("relearn_writes", r_wr, 1);
      check("relearn_ovf", r_ovf, 0);
      check("relearn_full", {bus.table_full, bus.table_count}, {1'b1, 6'(TD)});

      // Randomized traffic against the reference table.
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      ref_tab.delete();
      for (int n = 0; n < 160; n++) begin
         logic [47:0] da, sa;
         logic [2:0]  ing, e_idx;
         logic        e_flood, e_drop;
         int          e_lat, e_wr, e_del, e_ovf;
         if ($urandom_range(0, 4) == 0) begin
            sa    = pkey(int'($urandom_range(0, 39)));
            e_del = ref_tab.exists(sa) ? 1 : 0;
            if (e_del != 0) ref_tab.delete(sa);
            do_remove(sa);
            check("rnd_remove_deletes", r_del, e_del);
            check("rnd_remove_count", bus.table_count, ref_tab.num());
         end else begin
            da  = ($urandom_range(0, 9) == 0) ? BROADCAST_KEY : pkey(int'($urandom_range(0, 39)));
            sa  = pkey(int'($urandom_range(0, 39)));
            ing = 3'($urandom_range(0, 7));
            e_flood = da[GROUP_BIT] || !ref_tab.exists(da);
            e_drop  = 1'b0;
            e_idx   = 3'd0;
            if (!e_flood) begin
               if (ref_tab[da] == ing) e_drop = 1'b1;
               else                    e_idx  = ref_tab[da];
            end
            e_wr  = 0;
            e_del = 0;
            e_ovf = 0;
            if (ref_tab.exists(sa)) begin
               if (ref_tab[sa] == ing) begin
                  e_lat = 4;
               end else begin
                  e_lat = 6;
                  e_wr  = 1;
                  e_del = 1;
                  ref_tab[sa] = ing;
               end
            end else if (ref_tab.num() < TD) begin
               e_lat = 5;
               e_wr  = 1;
               ref_tab[sa] = ing;
            end else begin
               e_lat = 5;
               e_ovf = 1;
            end
            do_lookup(da, sa, ing, 0);
            check("rnd_flood", r_flood, e_flood);
            check("rnd_drop", r_drop, e_drop);
            check("rnd_index", (r_flood || r_drop) ? 3'd0 : r_idx, e_idx);
            check("rnd_latency", r_lat, e_lat);
            check("rnd_writes", r_wr, e_wr);
            check("rnd_deletes", r_del, e_del);
            check("rnd_overflow", r_ovf, e_ovf);
            check("rnd_count", bus.table_count, ref_tab.num());
            check("rnd_full", bus.table_full, ref_tab.num() == TD);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
